id_decode_redirect: RTL

//  Decode stage of the 5-stage MIPS pipeline; consumer end of the fetch interface. Holds the
//  IF/ID register, reads the register file, resolves beq/bne/j/jal/jr/jalr in ID and drives the

---
 rtl/id_decode_redirect.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/id_decode_redirect.sv
// ID stage of the 5-stage MIPS pipeline: IF/ID register, operand forwarding, hazard stall and
// in-ID branch/jump resolution. Define ID_REGIMM_BRANCH_EN to decode bltz/bgez (opcode 6'h01).
module id_decode_redirect #(
  parameter logic [31:0] PC_START = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_instr,
  input  logic        ex_wr_en,
  input  logic [4:0]  ex_wr_reg,
  input  logic        ex_is_load,
  input  logic        mem_wr_en,
  input  logic [4:0]  mem_wr_reg,
  input  logic        mem_is_load,
  input  logic [31:0] mem_fwd_data,
  output logic [4:0]  rf_rs_addr,
  output logic [4:0]  rf_rt_addr,
  input  logic [31:0] rf_rs_data,
  input  logic [31:0] rf_rt_data,
  output logic        stall,
  output logic        isBranch,
  output logic [31:0] branchAddr,
  output logic        isJump,
  output logic [25:0] jumpAddr,
  output logic        isJumpReg,
  output logic [31:0] jumpRegAddr,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic [31:0] id_rs_val,
  output logic [31:0] id_rt_val,
  output logic        link_en,
  output logic [31:0] link_addr,
  output logic        id_bubble
);

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;

  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_instr_q, id_instr_d;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt;
  logic        is_beq, is_bne, is_j, is_jal, is_jr, is_jalr, is_bltz, is_bgez;
  logic        uses_rs, uses_rt;
  logic        ex_load_hit, ex_dep_hit, mem_load_dep_hit;
  logic        stall_int, taken;
  logic [31:0] rs_val, rt_val;

  assign opcode = id_instr_q[31:26];
  assign rs     = id_instr_q[25:21];
  assign rt     = id_instr_q[20:16];
  assign funct  = id_instr_q[5:0];

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    is_beq  = (opcode == OP_BEQ);
    is_bne  = (opcode == OP_BNE);
    is_j    = (opcode == OP_J);
    is_jal  = (opcode == OP_JAL);
    is_jr   = (opcode == OP_SPECIAL) && (funct == FN_JR);
    is_jalr = (opcode == OP_SPECIAL) && (funct == FN_JALR);
    is_bltz = 1'b0;
    is_bgez = 1'b0;
`ifdef ID_REGIMM_BRANCH_EN
    is_bltz = (opcode == OP_REGIMM) && (rt == 5'h00);
    is_bgez = (opcode == OP_REGIMM) && (rt == 5'h01);
`else
    // REGIMM stays an unknown opcode in this build.
    if (opcode == OP_REGIMM) begin
      is_bltz = 1'b0;
      is_bgez = 1'b0;
    end
`endif
  end

  // Only non-load MEM results are forwarded; EX results never reach ID in time.
  always_comb begin
    rs_val = rf_rs_data;
    rt_val = rf_rt_data;
    if (mem_wr_en && !mem_is_load && mem_wr_reg == rs) rs_val = mem_fwd_data;
    if (mem_wr_en && !mem_is_load && mem_wr_reg == rt) rt_val = mem_fwd_data;
    if (rs == 5'd0) rs_val = 32'd0;
    if (rt == 5'd0) rt_val = 32'd0;
  end

  always_comb begin
    uses_rs = is_beq | is_bne | is_jr | is_jalr | is_bltz | is_bgez;
    uses_rt = is_beq | is_bne;
    ex_load_hit = ex_wr_en && ex_is_load &&
                  ((rs != 5'd0 && ex_wr_reg == rs) || (rt != 5'd0 && ex_wr_reg == rt));
    ex_dep_hit = ex_wr_en &&
                 ((uses_rs && rs != 5'd0 && ex_wr_reg == rs) ||
                  (uses_rt && rt != 5'd0 && ex_wr_reg == rt));
    mem_load_dep_hit = mem_wr_en && mem_is_load &&
                       ((uses_rs && rs != 5'd0 && mem_wr_reg == rs) ||
                        (uses_rt && rt != 5'd0 && mem_wr_reg == rt));
    stall_int = ex_load_hit | ex_dep_hit | mem_load_dep_hit;
    taken = (is_beq && rs_val == rt_val) || (is_bne && rs_val != rt_val) ||
            (is_bltz && rs_val[31]) || (is_bgez && !rs_val[31]);
  end

  // Synchronous reset is folded into the next-state logic and takes priority over stall.
  always_comb begin
    id_pc_d    = id_pc_q;
    id_instr_d = id_instr_q;
    if (reset) begin
      id_pc_d    = PC_START;
      id_instr_d = 32'd0;
    end else if (!stall_int) begin
      id_pc_d    = if_pc;
      id_instr_d = if_instr;
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    id_pc_q    <= id_pc_d;
    id_instr_q <= id_instr_d;
  end

  assign rf_rs_addr  = rs;
  assign rf_rt_addr  = rt;
  assign stall       = stall_int;
  assign id_bubble   = stall_int;
  assign isBranch    = taken && !stall_int;
  assign branchAddr  = {{16{id_instr_q[15]}}, id_instr_q[15:0]};
  assign isJump      = (is_j || is_jal) && !stall_int;
  assign jumpAddr    = id_instr_q[25:0];
  assign isJumpReg   = (is_jr || is_jalr) && !stall_int;
  assign jumpRegAddr = rs_val;
  assign link_en     = (is_jal || is_jalr) && !stall_int;
  assign link_addr   = id_pc_q + 32'd8;
  assign id_pc       = id_pc_q;
  assign id_instr    = id_instr_q;
  assign id_rs_val   = rs_val;
  assign id_rt_val   = rt_val;

endmodule
